// File: rtl/demux_dispatch.sv
// Registered 1-to-N demultiplexer: steers one producer word into a single-entry
// holding register per output slot (or all slots on broadcast), each drained independently.
module demux_dispatch #(
  parameter int switch_bits = 1,
  parameter int data_width  = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [switch_bits-1:0]                 in_sel,
  input  logic                                   in_bcast,
  input  logic [data_width-1:0]                  data_IN,
  output logic [(1<<switch_bits)-1:0]            out_valid,
  input  logic [(1<<switch_bits)-1:0]            out_ready,
  output logic [(1<<switch_bits)*data_width-1:0] data_OUT,
  output logic [15:0]                            count_OUT
);

  localparam int N = 1 << switch_bits;

  logic [N-1:0]          valid_q, valid_d;
  logic [N-1:0]          free;
  logic [N-1:0]          load;
  logic [data_width-1:0] data_q [N];
  logic [15:0]           count_q, count_d;
  logic                  xfer;

  // A slot popped this cycle counts as free, so a full slot with a ready
  // consumer still accepts a new word at full throughput.
  always_comb begin
    free     = ~valid_q | out_ready;
    in_ready = in_bcast ? &free : free[in_sel];
    xfer     = in_valid & in_ready;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
    load    = '0;
    count_d = count_q;
    if (xfer) begin
      count_d = count_q + 16'd1;
      for (int k = 0; k < N; k++) begin
        if (in_bcast || (int'(in_sel) == k)) load[k] = 1'b1;
      end
    end
    valid_d = (valid_q & ~out_ready) | load;
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  // NOTE: the data registers are reset as well, because data_OUT must read zero during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < N; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int k = 0; k < N; k++) begin
        if (load[k]) data_q[k] <= data_IN;
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_out
    assign data_OUT[k*data_width +: data_width] = data_q[k];
  end

  assign out_valid = valid_q;
  assign count_OUT = count_q;

endmodule
